// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one op in flight.
// Optional MDU_EARLY_OUT_EN: early multiply termination and leading-zero skip on divide.
module mdu_iterative #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [1:0]          r_op;
  logic                r_neg_q, r_neg_r;
  logic [2*XLEN-1:0]   r_prod, r_mcand;
  logic [XLEN-1:0]     r_mplier, r_div_b, r_quot, r_rem, r_resp_data;
  logic [5:0]          r_cnt;

  logic                w_accept, w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]     w_a_mag, w_b_mag, w_special_data;
  logic                w_div0, w_ovf, w_special;
  logic [2*XLEN-1:0]   w_prod_nxt, w_prod_fin;
  logic [XLEN-1:0]     w_mplier_nxt, w_rem_nxt, w_quot_nxt, w_mul_res, w_div_res;
  logic [XLEN:0]       w_rem_sh, w_rem_sub;
  logic                w_q_bit, w_mul_last, w_div_last;

  assign w_accept   = (r_state == S_IDLE) && req_valid && !flush;
  assign w_is_div   = req_op[2];
  assign w_a_signed = w_is_div ? !req_op[0] : (req_op[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? !req_op[0] : !req_op[1];
  assign w_a_neg    = w_a_signed && req_a[XLEN-1];
  assign w_b_neg    = w_b_signed && req_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -req_a : req_a;
  assign w_b_mag    = w_b_neg ? -req_b : req_b;

  assign w_div0    = w_is_div && (req_b == '0);
  assign w_ovf     = w_is_div && !req_op[0] && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
  assign w_special = w_div0 || w_ovf;
  // Overflow DIV returns the dividend itself (0x80000000); overflow REM returns 0
  assign w_special_data = w_div0 ? (req_op[1] ? req_a : '1) : (req_op[1] ? '0 : req_a);

`ifdef MDU_EARLY_OUT_EN
  function automatic logic [4:0] f_clz(input logic [XLEN-1:0] x);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      if (x[i]) n = 5'(XLEN - 1 - i);
    end
    return n;
  endfunction

  logic [4:0] w_lz;
  // A zero dividend still runs one iteration so latency never drops below 2
  assign w_lz = (w_a_mag == '0) ? 5'd31 : f_clz(w_a_mag);
`endif

  // One shift-add multiply step
  assign w_prod_nxt   = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_nxt = r_mplier >> 1;
  assign w_prod_fin   = r_neg_q ? -w_prod_nxt : w_prod_nxt;
  assign w_mul_res    = (r_op == 2'b00) ? w_prod_fin[XLEN-1:0] : w_prod_fin[2*XLEN-1:XLEN];

  // One restoring divide step; bit XLEN of the difference is the borrow
  assign w_rem_sh   = {r_rem, r_quot[XLEN-1]};
  assign w_rem_sub  = w_rem_sh - {1'b0, r_div_b};
  assign w_q_bit    = !w_rem_sub[XLEN];
  assign w_rem_nxt  = w_q_bit ? w_rem_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quot_nxt = {r_quot[XLEN-2:0], w_q_bit};
  assign w_div_res  = r_op[1] ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                              : (r_neg_q ? -w_quot_nxt : w_quot_nxt);

`ifdef MDU_EARLY_OUT_EN
  assign w_mul_last = (r_cnt == 6'd1) || (w_mplier_nxt == '0);
`else
  assign w_mul_last = (r_cnt == 6'd1);
`endif
  assign w_div_last = (r_cnt == 6'd1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (w_accept) w_next = w_special ? S_DONE : (w_is_div ? S_DIV : S_MUL);
      end
      S_MUL: begin
        if (flush)           w_next = S_IDLE;
        else if (w_mul_last) w_next = S_DONE;
      end
      S_DIV: begin
        if (flush)           w_next = S_IDLE;
        else if (w_div_last) w_next = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (flush || resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_prod      <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_div_b     <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_resp_data <= '0;
    end else if (w_accept) begin
      r_op     <= req_op[1:0];
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_prod   <= '0;
      r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
      r_div_b  <= w_b_mag;
      r_rem    <= '0;
`ifdef MDU_EARLY_OUT_EN
      r_quot   <= w_a_mag << w_lz;
      r_cnt    <= 6'(ITERS) - {1'b0, w_lz};
`else
      r_quot   <= w_a_mag;
      r_cnt    <= 6'(ITERS);
`endif
      if (w_special) r_resp_data <= w_special_data;
    end else if (!flush) begin
      case (r_state)
        S_MUL: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt - 6'd1;
          if (w_mul_last) r_resp_data <= w_mul_res;
        end
        S_DIV: begin
          r_rem  <= w_rem_nxt;
          r_quot <= w_quot_nxt;
          r_cnt  <= r_cnt - 6'd1;
          if (w_div_last) r_resp_data <= w_div_res;
        end
        default: ;
      endcase
    end
  end

  assign resp_data = r_resp_data;

endmodule
